// File: rtl/l2_victim_port.sv
// -----------------------------------------------------------------------------
// l2_victim_port
//
// L2-side initiator for the victim cache line interface. On an accepted L2
// miss it optionally writes back an evicted line, fetches the missing line,
// and hands the fetched line back to the L2 controller with a one-cycle done
// pulse.
//
// Optional feature (macro VC_EARLY_FILL_EN):
//   undefined - evicting requests run IDLE -> WB -> RD -> DONE -> IDLE
//               (writeback before the fetch).
//   defined   - evicting requests run IDLE -> RD -> DONE -> WB -> IDLE, so the
//               fill reaches the L2 before the writeback. The evicted line
//               stays in the capture buffer until written. l2_busy stays high
//               through the trailing writeback.
//
// Ports:
//   clk               system clock, rising edge
//   reset             synchronous, active-high
//   l2_req            miss request (level), sampled only while idle
//   l2_miss_address   address of the missing line
//   l2_evict          an evicted line accompanies this request
//   l2_evict_address  address of the evicted line
//   l2_evict_data     evicted line data
//   l2_busy           high from the cycle after accept until retirement
//   l2_done           one-cycle pulse, l2_fill_data valid
//   l2_fill_data      fetched line, held until the next fill
//   vc_read           read strobe to the victim cache
//   vc_write          write strobe to the victim cache
//   vc_address        line-aligned address (offset bits forced to zero)
//   vc_wdata          write burst data
//   vc_rdata          read burst data, valid with vc_resp
//   vc_resp           victim cache completion, one cycle per strobe
// -----------------------------------------------------------------------------
module l2_victim_port #(
    parameter int ADDR_WIDTH  = 16,
    parameter int LINE_WIDTH  = 128,
    parameter int OFFSET_BITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    // L2 controller side
    input  logic                  l2_req,
    input  logic [ADDR_WIDTH-1:0] l2_miss_address,
    input  logic                  l2_evict,
    input  logic [ADDR_WIDTH-1:0] l2_evict_address,
    input  logic [LINE_WIDTH-1:0] l2_evict_data,
    output logic                  l2_busy,
    output logic                  l2_done,
    output logic [LINE_WIDTH-1:0] l2_fill_data,
    // Victim cache side
    output logic                  vc_read,
    output logic                  vc_write,
    output logic [ADDR_WIDTH-1:0] vc_address,
    output logic [LINE_WIDTH-1:0] vc_wdata,
    input  logic [LINE_WIDTH-1:0] vc_rdata,
    input  logic                  vc_resp
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WB   = 2'd1,
        RD   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    // Request capture: loaded once at accept, never re-sampled mid-transaction,
    // so the L2 side is free to change its inputs after acceptance.
    logic [ADDR_WIDTH-1:0] miss_addr_p0;
    logic [ADDR_WIDTH-1:0] evict_addr_p0;
    logic [LINE_WIDTH-1:0] evict_data_p0;
    logic                  evict_p0;

    logic [LINE_WIDTH-1:0] fill_data;

    // Clears the line-offset bits of a byte address.
    function automatic logic [ADDR_WIDTH-1:0] align_line(input logic [ADDR_WIDTH-1:0] addr);
        return {addr[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
    endfunction

    // -------------------------------------------------------------------------
    // State and capture registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            miss_addr_p0  <= '0;
            evict_addr_p0 <= '0;
            evict_data_p0 <= '0;
            evict_p0      <= 1'b0;
            fill_data     <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && l2_req) begin
                miss_addr_p0  <= l2_miss_address;
                evict_addr_p0 <= l2_evict_address;
                evict_data_p0 <= l2_evict_data;
                evict_p0      <= l2_evict;
            end
            if (state == RD && vc_resp) begin
                fill_data <= vc_rdata;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next state and outputs. Strobes and address are decoded from the state
    // alone, so they drop the cycle after a reset is sampled and are zero in
    // IDLE/DONE. vc_resp outside WB/RD has no effect.
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state;
        vc_read    = 1'b0;
        vc_write   = 1'b0;
        vc_address = '0;
        vc_wdata   = '0;
        l2_done    = 1'b0;
        l2_busy    = (state != IDLE);

        case (state)
            IDLE: begin
                if (l2_req) begin
`ifdef VC_EARLY_FILL_EN
                    // Fetch first; any writeback trails the done pulse.
                    state_next = RD;
`else
                    state_next = l2_evict ? WB : RD;
`endif
                end
            end

            WB: begin
                vc_write   = 1'b1;
                vc_address = align_line(evict_addr_p0);
                vc_wdata   = evict_data_p0;
                if (vc_resp) begin
`ifdef VC_EARLY_FILL_EN
                    state_next = IDLE;
`else
                    state_next = RD;
`endif
                end
            end

            RD: begin
                vc_read    = 1'b1;
                vc_address = align_line(miss_addr_p0);
                if (vc_resp) begin
                    state_next = DONE;
                end
            end

            DONE: begin
                l2_done = 1'b1;
`ifdef VC_EARLY_FILL_EN
                state_next = evict_p0 ? WB : IDLE;
`else
                state_next = IDLE;
`endif
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign l2_fill_data = fill_data;

endmodule

// File: tb/tb_l2_victim_port.sv
module tb_l2_victim_port;

    localparam int AW = 16;
    localparam int LW = 128;

    logic          clk = 1'b0;
    logic          reset;
    logic          l2_req;
    logic [AW-1:0] l2_miss_address;
    logic          l2_evict;
    logic [AW-1:0] l2_evict_address;
    logic [LW-1:0] l2_evict_data;
    logic          l2_busy;
    logic          l2_done;
    logic [LW-1:0] l2_fill_data;
    logic          vc_read;
    logic          vc_write;
    logic [AW-1:0] vc_address;
    logic [LW-1:0] vc_wdata;
    logic [LW-1:0] vc_rdata;
    logic          vc_resp;

    l2_victim_port #(
        .ADDR_WIDTH (AW),
        .LINE_WIDTH (LW),
        .OFFSET_BITS(4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .l2_req          (l2_req),
        .l2_miss_address (l2_miss_address),
        .l2_evict        (l2_evict),
        .l2_evict_address(l2_evict_address),
        .l2_evict_data   (l2_evict_data),
        .l2_busy         (l2_busy),
        .l2_done         (l2_done),
        .l2_fill_data    (l2_fill_data),
        .vc_read         (vc_read),
        .vc_write        (vc_write),
        .vc_address      (vc_address),
        .vc_wdata        (vc_wdata),
        .vc_rdata        (vc_rdata),
        .vc_resp         (vc_resp)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [LW-1:0] exp_q[$];
    logic [LW-1:0] mon_exp;

    typedef struct {
        logic [AW-1:0] miss;
        logic          ev;
        logic [AW-1:0] ev_addr;
        logic [LW-1:0] ev_data;
        logic [LW-1:0] rdata;
        int            wwb;      // wait cycles before the write response
        int            wrd;      // wait cycles before the read response
        logic          hold;     // keep l2_req high after accept
        logic [AW-1:0] exp_wb;   // expected writeback address
        logic [AW-1:0] exp_rd;   // expected fetch address
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [AW-1:0] miss, input logic ev, input logic [AW-1:0] ev_addr,
                                input logic [LW-1:0] ev_data, input logic [LW-1:0] rdata,
                                input int wwb, input int wrd, input logic hold,
                                input logic [AW-1:0] exp_wb, input logic [AW-1:0] exp_rd);
        vec_t v;
        v.miss = miss; v.ev = ev; v.ev_addr = ev_addr; v.ev_data = ev_data; v.rdata = rdata;
        v.wwb = wwb; v.wrd = wrd; v.hold = hold; v.exp_wb = exp_wb; v.exp_rd = exp_rd;
        return v;
    endfunction

    function automatic logic [LW-1:0] rnd_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Scoreboard: every l2_done pops the oldest expected fill.
    always @(negedge clk) begin
        if (reset === 1'b0 && l2_done === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got l2_done=1 expected no pending fill");
            end else begin
                mon_exp = exp_q.pop_front();
                check("sb_fill", l2_fill_data, mon_exp);
            end
        end
    end

    task automatic wb_phase(input vec_t v);
        for (int w = 0; w <= v.wwb; w++) begin
            check("wb_write", vc_write, 1);
            check("wb_read", vc_read, 0);
            check("wb_addr", vc_address, v.exp_wb);
            check("wb_wdata", vc_wdata, v.ev_data);
            check("wb_busy", l2_busy, 1);
            check("wb_done", l2_done, 0);
            vc_resp = (w == v.wwb);
            @(posedge clk); #1;
            vc_resp = 1'b0;
        end
    endtask

    task automatic rd_phase(input vec_t v);
        for (int w = 0; w <= v.wrd; w++) begin
            check("rd_read", vc_read, 1);
            check("rd_write", vc_write, 0);
            check("rd_addr", vc_address, v.exp_rd);
            check("rd_busy", l2_busy, 1);
            check("rd_done", l2_done, 0);
            vc_resp  = (w == v.wrd);
            vc_rdata = (w == v.wrd) ? v.rdata : rnd_line();
            @(posedge clk); #1;
            vc_resp  = 1'b0;
            vc_rdata = rnd_line();
        end
    endtask

    task automatic done_phase(input vec_t v);
        check("done_pulse", l2_done, 1);
        check("done_busy", l2_busy, 1);
        check("done_strobes", {vc_read, vc_write}, 0);
        check("done_fill", l2_fill_data, v.rdata);
        @(posedge clk); #1;
    endtask

    // Called while the DUT is idle; returns in the first idle cycle after retirement.
    task automatic run_txn(input vec_t v);
        l2_req           = 1'b1;
        l2_miss_address  = v.miss;
        l2_evict         = v.ev;
        l2_evict_address = v.ev_addr;
        l2_evict_data    = v.ev_data;
        @(posedge clk); #1;
        exp_q.push_back(v.rdata);
        if (!v.hold) l2_req = 1'b0;
        // The DUT must ignore these once the request is accepted.
        l2_miss_address  = AW'($urandom);
        l2_evict         = 1'($urandom);
        l2_evict_address = AW'($urandom);
        l2_evict_data    = rnd_line();
`ifdef VC_EARLY_FILL_EN
        rd_phase(v);
        done_phase(v);
        if (v.ev) wb_phase(v);
`else
        if (v.ev) wb_phase(v);
        rd_phase(v);
        done_phase(v);
`endif
        check("idle_busy", l2_busy, 0);
        check("idle_done", l2_done, 0);
        check("idle_strobes", {vc_read, vc_write}, 0);
        check("idle_fill_hold", l2_fill_data, v.rdata);
    endtask

    initial begin
        reset            = 1'b1;
        l2_req           = 1'b1;
        l2_miss_address  = 16'h1234;
        l2_evict         = 1'b0;
        l2_evict_address = '0;
        l2_evict_data    = '0;
        vc_rdata         = '0;
        vc_resp          = 1'b0;

        vecs[0] = mk(16'h1234, 1'b0, 16'h0000, '0, {16{8'hA5}}, 0, 3, 1'b0, 16'h0000, 16'h1230);
        vecs[1] = mk(16'h2008, 1'b1, 16'h40FF, 128'h1, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0F0F_F0F0, 2, 1, 1'b0, 16'h40F0, 16'h2000);
        vecs[2] = mk(16'hFFFF, 1'b0, 16'h0000, '0, {8{16'h5A3C}}, 0, 0, 1'b1, 16'h0000, 16'hFFF0);
        vecs[3] = mk(16'h000F, 1'b1, 16'hABCD, {4{32'hCAFE_F00D}}, {LW{1'b1}}, 0, 0, 1'b1, 16'hABC0, 16'h0000);
        vecs[4] = mk(16'h8001, 1'b0, 16'h0000, '0, 128'h8000_0000_0000_0000_0000_0000_0000_0001, 0, 0, 1'b0, 16'h0000, 16'h8000);
        vecs[5] = mk(16'h5555, 1'b1, 16'h5555, {8{16'h1111}}, {8{16'h2222}}, 1, 2, 1'b0, 16'h5550, 16'h5550);

        // Reset held two cycles with a request pending: everything stays zero.
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            check("rst_busy", l2_busy, 0);
            check("rst_done", l2_done, 0);
            check("rst_strobes", {vc_read, vc_write}, 0);
            check("rst_addr", vc_address, 0);
            check("rst_wdata", vc_wdata, 0);
            check("rst_fill", l2_fill_data, 0);
        end
        reset = 1'b0;

        // Table: clean, dirty, back-to-back held requests, aligned-offset edges,
        // and a miss to the same line as the eviction.
        for (int i = 0; i < 6; i++) begin
            run_txn(vecs[i]);
        end

        // vc_resp while idle is ignored.
        l2_req   = 1'b0;
        vc_resp  = 1'b1;
        vc_rdata = rnd_line();
        @(posedge clk); #1;
        vc_resp = 1'b0;
        check("idle_resp_busy", l2_busy, 0);
        check("idle_resp_strobes", {vc_read, vc_write}, 0);
        check("idle_resp_fill", l2_fill_data, vecs[5].rdata);

        // Reset while waiting on the first strobe of an evicting request.
        l2_req           = 1'b1;
        l2_miss_address  = 16'h3456;
        l2_evict         = 1'b1;
        l2_evict_address = 16'h7777;
        l2_evict_data    = {4{32'h1357_9BDF}};
        @(posedge clk); #1;
        l2_req = 1'b0;
        for (int c = 0; c < 3; c++) begin
`ifdef VC_EARLY_FILL_EN
            check("abort_strobe", vc_read, 1);
            check("abort_addr", vc_address, 16'h3450);
`else
            check("abort_strobe", vc_write, 1);
            check("abort_addr", vc_address, 16'h7770);
`endif
            if (c < 2) begin
                @(posedge clk); #1;
            end
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_strobes", {vc_read, vc_write}, 0);
        check("abort_busy", l2_busy, 0);
        check("abort_done", l2_done, 0);
        check("abort_addr0", vc_address, 0);
        check("abort_wdata0", vc_wdata, 0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check("abort_no_done", l2_done, 0);
            check("abort_idle", l2_busy, 0);
        end

        // A later request completes normally.
        run_txn(vecs[1]);

        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d pending fills expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
